switch_output_scheduler: RTL and testbench



---
 rtl/switch_output_scheduler.sv | 173 +++++++++++++++++
 tb/tb_switch_output_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_output_scheduler.sv
// -----------------------------------------------------------------------------
// switch_output_scheduler
//
// Per-output round-robin scheduler for a 4-port switch. Each cycle it chooses
// which input FIFO head drives each output port. A head may carry a multi-hot
// target mask. A multicast head can be served across several cycles. Its
// still-unserved targets are remembered, and the head is popped once every
// target has been served. Each input also has a sticky starvation flag.
//
// Ports
//   clk               system clock
//   rst               asynchronous, active-high reset
//   head_valid[i]     input FIFO i has a head packet
//   head_target       [4i+3:4i] multi-hot target mask of head i
//   out_ready[j]      output j can accept a packet this cycle
//   grant             [4i+j] input i transfers to output j this cycle
//   out_valid[j]      output j is transferring this cycle
//   out_src           [2j+1:2j] input driving output j (0 when idle)
//   head_pop[i]       pop input FIFO i at the end of this cycle
//   zero_target_drop  head i popped because its target mask is empty
//   starved[i]        sticky: head i waited MAX_WAIT cycles without a grant
// -----------------------------------------------------------------------------
module switch_output_scheduler #(
  parameter int N_PORTS  = 4,
  parameter int PTR_W    = 2,
  parameter int MAX_WAIT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         head_valid,
  input  logic [N_PORTS*N_PORTS-1:0] head_target,
  input  logic [N_PORTS-1:0]         out_ready,
  output logic [N_PORTS*N_PORTS-1:0] grant,
  output logic [N_PORTS-1:0]         out_valid,
  output logic [N_PORTS*PTR_W-1:0]   out_src,
  output logic [N_PORTS-1:0]         head_pop,
  output logic [N_PORTS-1:0]         zero_target_drop,
  output logic [N_PORTS-1:0]         starved
);

  localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  // State
  logic [PTR_W-1:0]   rr_ptr_q   [N_PORTS];
  logic [PTR_W-1:0]   rr_ptr_d   [N_PORTS];
  logic [N_PORTS-1:0] rem_valid_q;
  logic [N_PORTS-1:0] rem_valid_d;
  logic [N_PORTS-1:0] rem_mask_q [N_PORTS];
  logic [N_PORTS-1:0] rem_mask_d [N_PORTS];
  logic [CNT_W-1:0]   wait_cnt_q [N_PORTS];
  logic [CNT_W-1:0]   wait_cnt_d [N_PORTS];
  logic [N_PORTS-1:0] starved_q;
  logic [N_PORTS-1:0] starved_d;

  // Combinational per-input views
  logic [N_PORTS-1:0] eff_s  [N_PORTS];  // targets still to be served
  logic [N_PORTS-1:0] req_s  [N_PORTS];  // eff masked by head_valid
  logic [N_PORTS-1:0] gnt_s  [N_PORTS];  // row i: outputs granted to input i
  logic [N_PORTS-1:0] left_s [N_PORTS];  // targets still pending after this cycle

  // Effective mask: a partially served head uses its remembered remainder.
  // head_target is ignored until that remainder has been fully delivered.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      eff_s[i] = rem_valid_q[i] ? rem_mask_q[i] : head_target[i*N_PORTS +: N_PORTS];
      req_s[i] = eff_s[i] & {N_PORTS{head_valid[i]}};
    end
  end

  // Round-robin arbitration, independent for each output, starting at rr_ptr.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             found;
    for (int i = 0; i < N_PORTS; i++) begin
      gnt_s[i] = '0;
    end
    out_valid = '0;
    out_src   = '0;
    idx       = '0;
    found     = 1'b0;
    for (int j = 0; j < N_PORTS; j++) begin
      found = 1'b0;
      for (int k = 0; k < N_PORTS; k++) begin
        // Natural wrap of the PTR_W-bit sum gives the modulo search order.
        idx = rr_ptr_q[j] + PTR_W'(k);
        if (out_ready[j] && !found && req_s[idx][j]) begin
          gnt_s[idx][j]               = 1'b1;
          found                       = 1'b1;
          out_valid[j]                = 1'b1;
          out_src[j*PTR_W +: PTR_W]   = idx;
        end else begin
          found = found;
        end
      end
    end
  end

  // Flatten grants and derive pop / zero-target drop.
  always_comb begin
    grant            = '0;
    head_pop         = '0;
    zero_target_drop = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      left_s[i]                     = eff_s[i] & ~gnt_s[i];
      grant[i*N_PORTS +: N_PORTS]   = gnt_s[i];
      // An empty mask leaves nothing pending, so it pops with no grant.
      head_pop[i]                   = head_valid[i] & (left_s[i] == '0);
      zero_target_drop[i]           = head_valid[i] & ~rem_valid_q[i] &
                                      (head_target[i*N_PORTS +: N_PORTS] == '0);
    end
  end

  // Next-state: pointers, multicast remainder, wait counters, starvation.
  always_comb begin
    rem_valid_d = rem_valid_q;
    starved_d   = starved_q;
    for (int j = 0; j < N_PORTS; j++) begin
      if (out_valid[j]) begin
        rr_ptr_d[j] = out_src[j*PTR_W +: PTR_W] + PTR_W'(1);
      end else begin
        rr_ptr_d[j] = rr_ptr_q[j];
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (head_pop[i]) begin
        rem_valid_d[i] = 1'b0;
        rem_mask_d[i]  = '0;
      end else if (gnt_s[i] != '0) begin
        rem_valid_d[i] = 1'b1;
        rem_mask_d[i]  = left_s[i];
      end else begin
        // No grant or invalid head: an abandoned remainder is kept.
        rem_valid_d[i] = rem_valid_q[i];
        rem_mask_d[i]  = rem_mask_q[i];
      end

      if (!head_valid[i] || (gnt_s[i] != '0)) begin
        wait_cnt_d[i] = '0;
      end else if (wait_cnt_q[i] != CNT_MAX) begin
        wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
      end else begin
        wait_cnt_d[i] = wait_cnt_q[i];
      end

      starved_d[i] = starved_q[i] | (wait_cnt_d[i] == CNT_MAX);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_valid_q <= '0;
      starved_q   <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        rr_ptr_q[i]   <= '0;
        rem_mask_q[i] <= '0;
        wait_cnt_q[i] <= '0;
      end
    end else begin
      rem_valid_q <= rem_valid_d;
      starved_q   <= starved_d;
      for (int i = 0; i < N_PORTS; i++) begin
        rr_ptr_q[i]   <= rr_ptr_d[i];
        rem_mask_q[i] <= rem_mask_d[i];
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end

  assign starved = starved_q;

endmodule

// File: tb/tb_switch_output_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for switch_output_scheduler (MAX_WAIT reduced to 8).
// Directed table of vectors, hand sequences for starvation and asynchronous
// reset, then randomized stimulus checked against a reference model.
// -----------------------------------------------------------------------------
module tb_switch_output_scheduler;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  hv;
  logic [15:0] ht;
  logic [3:0]  ordy;
  logic [15:0] grant;
  logic [3:0]  ov;
  logic [7:0]  src;
  logic [3:0]  pop;
  logic [3:0]  ztd;
  logic [3:0]  starved;

  always #5 clk = ~clk;

  switch_output_scheduler #(
    .N_PORTS  (4),
    .PTR_W    (2),
    .MAX_WAIT (MW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .head_valid       (hv),
    .head_target      (ht),
    .out_ready        (ordy),
    .grant            (grant),
    .out_valid        (ov),
    .out_src          (src),
    .head_pop         (pop),
    .zero_target_drop (ztd),
    .starved          (starved)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr  [4];
  logic        m_remv [4];
  logic [3:0]  m_remm [4];
  logic [3:0]  m_want [4];
  int          m_wait [4];
  logic [3:0]  m_starv;
  logic [15:0] e_grant;
  logic [3:0]  e_ov, e_pop, e_ztd;
  logic [7:0]  e_src;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_ptr[i]  = 0;
      m_remv[i] = 1'b0;
      m_remm[i] = 4'b0;
      m_wait[i] = 0;
    end
    m_starv = 4'b0;
  endtask

  // Winner for output j is the requester closest (cyclically) after the pointer.
  task automatic m_eval();
    int best;
    int bestd;
    int d;
    logic [3:0] got;
    for (int i = 0; i < 4; i++) begin
      m_want[i] = hv[i] ? (m_remv[i] ? m_remm[i] : ht[4*i +: 4]) : 4'b0;
    end
    e_grant = 16'h0;
    e_ov    = 4'h0;
    e_src   = 8'h0;
    for (int j = 0; j < 4; j++) begin
      best  = -1;
      bestd = 99;
      if (ordy[j]) begin
        for (int i = 0; i < 4; i++) begin
          d = (i - m_ptr[j] + 4) % 4;
          if (m_want[i][j] && d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
      end
      if (best >= 0) begin
        e_grant[4*best + j] = 1'b1;
        e_ov[j]             = 1'b1;
        e_src[2*j +: 2]     = best[1:0];
      end
    end
    for (int i = 0; i < 4; i++) begin
      got      = e_grant[4*i +: 4];
      e_pop[i] = hv[i] && ((m_want[i] & ~got) == 4'b0);
      e_ztd[i] = hv[i] && !m_remv[i] && (ht[4*i +: 4] == 4'b0);
    end
  endtask

  task automatic m_commit();
    logic [3:0] got;
    for (int j = 0; j < 4; j++) begin
      if (e_ov[j]) m_ptr[j] = (int'(e_src[2*j +: 2]) + 1) % 4;
    end
    for (int i = 0; i < 4; i++) begin
      got = e_grant[4*i +: 4];
      if (e_pop[i]) begin
        m_remv[i] = 1'b0;
      end else if (got != 4'b0) begin
        m_remv[i] = 1'b1;
        m_remm[i] = m_want[i] & ~got;
      end
      if (!hv[i] || got != 4'b0) m_wait[i] = 0;
      else if (m_wait[i] < MW) m_wait[i]++;
      if (m_wait[i] >= MW) m_starv[i] = 1'b1;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        do_rst;
    logic [3:0]  hv;
    logic [15:0] ht;
    logic [3:0]  ordy;
    logic [15:0] e_grant;
    logic [3:0]  e_ov;
    logic [7:0]  e_src;
    logic [3:0]  e_pop;
    logic [3:0]  e_ztd;
  } vec_t;

  vec_t vecs [13];

  task automatic do_reset();
    rst  = 1'b1;
    hv   = 4'h0;
    ht   = 16'h0;
    ordy = 4'h0;
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // unicast contention on output 0, pointer wraps after input 3
    vecs[0]  = '{1'b1, 4'hF, 16'h1111, 4'hF, 16'h0001, 4'h1, 8'h00, 4'h1, 4'h0};
    vecs[1]  = '{1'b0, 4'hF, 16'h1111, 4'hF, 16'h0010, 4'h1, 8'h01, 4'h2, 4'h0};
    vecs[2]  = '{1'b0, 4'hF, 16'h1111, 4'hF, 16'h0100, 4'h1, 8'h02, 4'h4, 4'h0};
    vecs[3]  = '{1'b0, 4'hF, 16'h1111, 4'hF, 16'h1000, 4'h1, 8'h03, 4'h8, 4'h0};
    vecs[4]  = '{1'b0, 4'hF, 16'h1111, 4'hF, 16'h0001, 4'h1, 8'h00, 4'h1, 4'h0};
    // full parallel
    vecs[5]  = '{1'b1, 4'hF, 16'h8421, 4'hF, 16'h8421, 4'hF, 8'hE4, 4'hF, 4'h0};
    // split multicast
    vecs[6]  = '{1'b1, 4'h3, 16'h0027, 4'hF, 16'h0007, 4'h7, 8'h00, 4'h1, 4'h0};
    vecs[7]  = '{1'b0, 4'h2, 16'h0027, 4'hF, 16'h0020, 4'h2, 8'h04, 4'h2, 4'h0};
    vecs[8]  = '{1'b0, 4'h1, 16'h0006, 4'hB, 16'h0002, 4'h2, 8'h00, 4'h0, 4'h0};
    vecs[9]  = '{1'b0, 4'h1, 16'h0001, 4'hF, 16'h0004, 4'h4, 8'h00, 4'h1, 4'h0};
    vecs[10] = '{1'b0, 4'h1, 16'h0001, 4'hF, 16'h0001, 4'h1, 8'h00, 4'h1, 4'h0};
    // zero target, then full backpressure
    vecs[11] = '{1'b1, 4'h4, 16'h0000, 4'hF, 16'h0000, 4'h0, 8'h00, 4'h4, 4'h4};
    vecs[12] = '{1'b0, 4'hF, 16'h8421, 4'h0, 16'h0000, 4'h0, 8'h00, 4'h0, 4'h0};

    rst  = 1'b1;
    hv   = 4'h0;
    ht   = 16'h0;
    ordy = 4'h0;

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].do_rst) do_reset();
      hv   = vecs[v].hv;
      ht   = vecs[v].ht;
      ordy = vecs[v].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d grant", v), grant, vecs[v].e_grant);
      chk($sformatf("vec%0d out_valid", v), {12'h0, ov}, {12'h0, vecs[v].e_ov});
      chk($sformatf("vec%0d out_src", v), {8'h0, src}, {8'h0, vecs[v].e_src});
      chk($sformatf("vec%0d head_pop", v), {12'h0, pop}, {12'h0, vecs[v].e_pop});
      chk($sformatf("vec%0d zero_drop", v), {12'h0, ztd}, {12'h0, vecs[v].e_ztd});
      @(posedge clk);
      #1;
    end

    // ---------------- starvation and asynchronous reset ----------------
    do_reset();
    chk("reset starved", {12'h0, starved}, 16'h0);
    hv   = 4'h8;
    ht   = 16'h1000;
    ordy = 4'hE;
    for (int k = 0; k < MW; k++) begin
      @(negedge clk);
      chk($sformatf("starve wait%0d", k), {12'h0, starved}, 16'h0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("starve set", {12'h0, starved}, 16'h8);
    ordy = 4'hF;
    #1;
    chk("starve served grant", grant, 16'h1000);
    chk("starve served pop", {12'h0, pop}, 16'h8);
    @(posedge clk);
    #1;
    hv   = 4'h0;
    @(negedge clk);
    chk("starve sticky", {12'h0, starved}, 16'h8);
    // partial multicast on input 0; output 0 pointer has wrapped to 0
    hv   = 4'h3;
    ht   = 16'h0013;
    ordy = 4'h1;
    #1;
    chk("partial grant", grant, 16'h0001);
    chk("partial pop", {12'h0, pop}, 16'h0);
    @(posedge clk);
    #1;
    ordy = 4'h3;
    #1;
    chk("pre-reset grant", grant, 16'h0012);
    rst = 1'b1;
    #1;
    chk("async rst grant", grant, 16'h0003);
    chk("async rst pop", {12'h0, pop}, 16'h1);
    chk("async rst starved", {12'h0, starved}, 16'h0);
    hv = 4'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---------------- randomized against the reference model ----------------
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 149) do_reset();
      for (int i = 0; i < 4; i++) begin
        hv[i]        = ($urandom_range(0, 3) != 0);
        ordy[i]      = ($urandom_range(0, 2) != 0);
        ht[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      // a stretch where output 0 is blocked to exercise starvation
      if (c >= 200 && c < 260) begin
        ordy[0] = 1'b0;
        hv[2]   = 1'b1;
        ht[11:8] = 4'h1;
      end
      @(negedge clk);
      m_eval();
      chk($sformatf("rnd%0d grant", c), grant, e_grant);
      chk($sformatf("rnd%0d out_valid", c), {12'h0, ov}, {12'h0, e_ov});
      chk($sformatf("rnd%0d out_src", c), {8'h0, src}, {8'h0, e_src});
      chk($sformatf("rnd%0d head_pop", c), {12'h0, pop}, {12'h0, e_pop});
      chk($sformatf("rnd%0d zero_drop", c), {12'h0, ztd}, {12'h0, e_ztd});
      chk($sformatf("rnd%0d starved", c), {12'h0, starved}, {12'h0, m_starv});
      @(posedge clk);
      m_commit();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
